// File: rtl/multdiv_issue_ctrl.sv
// rtl/multdiv_issue_ctrl.sv - issue/stall/writeback sequencer for the multi-cycle mul/div unit
// Holds the PC while one mul/div runs, then writes the result, or the status code into rstatus.
module multdiv_issue_ctrl #(
  parameter int DATA_W      = 32,
  parameter int TIMEOUT     = 40,
  parameter int RSTATUS_REG = 30,
  parameter int MUL_EXC     = 1,
  parameter int DIV_EXC     = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic              issue_is_div,
  input  logic [4:0]        issue_rd,
  input  logic [DATA_W-1:0] issue_a,
  input  logic [DATA_W-1:0] issue_b,
  input  logic              md_ready,
  input  logic              md_exception,
  input  logic [DATA_W-1:0] md_result,
  output logic              stall,
  output logic              busy,
  output logic              md_ctrl_mult,
  output logic              md_ctrl_div,
  output logic [DATA_W-1:0] md_operand_a,
  output logic [DATA_W-1:0] md_operand_b,
  output logic              wb_en,
  output logic [4:0]        wb_reg,
  output logic [DATA_W-1:0] wb_data,
  output logic              exc_flag
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_WB    = 2'd3
  } state_t;

  state_t           state;
  logic             op_div;
  logic [4:0]       rd_q;
  logic [CNT_W-1:0] count;
  logic             timeout_hit;

  assign timeout_hit = (count == CNT_LAST);
  assign busy        = (state != ST_IDLE);

  // The IDLE term is combinational so the PC is held in the very cycle decode presents the op.
  assign stall = (state == ST_START) || (state == ST_WAIT) ||
                 ((state == ST_IDLE) && issue_valid && reset);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      op_div       <= 1'b0;
      rd_q         <= 5'd0;
      count        <= '0;
      md_ctrl_mult <= 1'b0;
      md_ctrl_div  <= 1'b0;
      md_operand_a <= '0;
      md_operand_b <= '0;
      wb_en        <= 1'b0;
      wb_reg       <= 5'd0;
      wb_data      <= '0;
      exc_flag     <= 1'b0;
    end else begin
      md_ctrl_mult <= 1'b0;
      md_ctrl_div  <= 1'b0;
      wb_en        <= 1'b0;
      wb_reg       <= 5'd0;
      wb_data      <= '0;
      exc_flag     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (issue_valid) begin
            op_div       <= issue_is_div;
            rd_q         <= issue_rd;
            md_operand_a <= issue_a;
            md_operand_b <= issue_b;
            md_ctrl_mult <= ~issue_is_div;
            md_ctrl_div  <= issue_is_div;
            state        <= ST_START;
          end
        end
        ST_START: begin
          count <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (count != CNT_SAT) count <= count + 1'b1;
          // A ready arriving on the timeout cycle still delivers its real result.
          if (md_ready) begin
            state <= ST_WB;
            if (md_exception) begin
              wb_en    <= 1'b1;
              wb_reg   <= 5'(RSTATUS_REG);
              wb_data  <= DATA_W'(op_div ? DIV_EXC : MUL_EXC);
              exc_flag <= 1'b1;
            end else if (rd_q != 5'd0) begin
              wb_en   <= 1'b1;
              wb_reg  <= rd_q;
              wb_data <= md_result;
            end
          end else if (timeout_hit) begin
            state    <= ST_WB;
            wb_en    <= 1'b1;
            wb_reg   <= 5'(RSTATUS_REG);
            wb_data  <= DATA_W'(op_div ? DIV_EXC : MUL_EXC);
            exc_flag <= 1'b1;
          end
        end
        ST_WB: begin
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// tb/tb_multdiv_issue_ctrl.sv - randomized checks of multdiv_issue_ctrl against a transaction-level model
module tb_multdiv_issue_ctrl;

  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 40;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              issue_valid = 1'b0;
  logic              issue_is_div = 1'b0;
  logic [4:0]        issue_rd = 5'd0;
  logic [DATA_W-1:0] issue_a = '0;
  logic [DATA_W-1:0] issue_b = '0;
  logic              md_ready = 1'b0;
  logic              md_exception = 1'b0;
  logic [DATA_W-1:0] md_result = '0;
  logic              stall, busy, md_ctrl_mult, md_ctrl_div, wb_en, exc_flag;
  logic [DATA_W-1:0] md_operand_a, md_operand_b, wb_data;
  logic [4:0]        wb_reg;

  int total = 0;
  int bad   = 0;

  multdiv_issue_ctrl #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset),
    .issue_valid(issue_valid), .issue_is_div(issue_is_div), .issue_rd(issue_rd),
    .issue_a(issue_a), .issue_b(issue_b),
    .md_ready(md_ready), .md_exception(md_exception), .md_result(md_result),
    .stall(stall), .busy(busy), .md_ctrl_mult(md_ctrl_mult), .md_ctrl_div(md_ctrl_div),
    .md_operand_a(md_operand_a), .md_operand_b(md_operand_b),
    .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data), .exc_flag(exc_flag)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // k = WAIT cycle on which md_ready arrives (0 = never). keep holds issue_valid high in WB.
  task automatic run_op(input bit is_div, input logic [4:0] rd, input logic [31:0] a,
                        input logic [31:0] b, input int k, input bit exc,
                        input logic [31:0] result, input bit keep);
    int waits, stall_n, mult_n, div_n, wb_cyc, early;
    bit exc_path, opnd_ok, ctrl_wb, busy_wb, en_wb, excf_wb;
    logic [4:0]  exp_reg, got_reg;
    logic [31:0] exp_data, got_data;
    logic        exp_en;
    waits    = (k >= 1 && k <= TIMEOUT) ? k : TIMEOUT;
    exc_path = (waits != k) || exc;
    if (exc_path) begin
      exp_en = 1'b1; exp_reg = 5'd30; exp_data = is_div ? 32'd2 : 32'd1;
    end else begin
      exp_en = (rd != 5'd0); exp_reg = exp_en ? rd : 5'd0; exp_data = exp_en ? result : 32'd0;
    end
    stall_n = 0; mult_n = 0; div_n = 0; wb_cyc = 0; early = 0;
    opnd_ok = 1; ctrl_wb = 0; busy_wb = 0; en_wb = 0; excf_wb = 0;
    got_reg = '0; got_data = '0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clock);
      issue_valid  = (c == 1) || (keep && c == waits + 3);
      issue_is_div = (c == 1) ? is_div : 1'($urandom);
      issue_rd     = (c == 1) ? rd : 5'($urandom);
      issue_a      = (c == 1) ? a : $urandom;
      issue_b      = (c == 1) ? b : $urandom;
      if (k > 0 && c == 2 + k) begin
        md_ready = 1'b1; md_exception = exc; md_result = result;
      end else begin
        md_ready     = (c <= 2) ? 1'($urandom) : 1'b0;
        md_exception = 1'($urandom);
        md_result    = $urandom;
      end
      #1;
      if (stall) stall_n++;
      if (md_ctrl_mult) mult_n++;
      if (md_ctrl_div) div_n++;
      if ((md_ctrl_mult || md_ctrl_div) && (md_operand_a !== a || md_operand_b !== b)) opnd_ok = 0;
      if (c >= 2 && !stall) begin
        wb_cyc = c; ctrl_wb = md_ctrl_mult | md_ctrl_div; busy_wb = busy;
        en_wb = wb_en; excf_wb = exc_flag; got_reg = wb_reg; got_data = wb_data;
        if (md_operand_a !== a || md_operand_b !== b) opnd_ok = 0;
        break;
      end
      if (wb_en || exc_flag) early++;
    end
    md_ready = 1'b0;
    chk("stall_cycles", 64'(stall_n), 64'(waits + 2));
    chk("wb_cycle", 64'(wb_cyc), 64'(waits + 3));
    chk("pulse_mul", 64'(mult_n), 64'(!is_div));
    chk("pulse_div", 64'(div_n), 64'(is_div));
    chk("wb_en", 64'(en_wb), 64'(exp_en));
    chk("wb_reg", 64'(got_reg), 64'(exp_reg));
    chk("wb_data", 64'(got_data), 64'(exp_data));
    chk("exc_flag", 64'(excf_wb), 64'(exc_path));
    chk("busy_in_wb", 64'(busy_wb), 64'd1);
    chk("ctrl_in_wb", 64'(ctrl_wb), 64'd0);
    chk("operands", 64'(opnd_ok), 64'd1);
    chk("early_wb", 64'(early), 64'd0);
  endtask

  initial begin
    int quiet;
    issue_valid = 1'b1;
    #3;
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_outs", 64'({md_ctrl_mult, md_ctrl_div, wb_en, exc_flag}), 64'd0);
    chk("rst_data", 64'({wb_reg, wb_data, md_operand_a, md_operand_b}), 64'd0);
    @(negedge clock);
    issue_valid = 1'b0;
    reset = 1'b1;

    run_op(1'b0, 5'd5, 32'd3, 32'd7, 4, 1'b0, 32'd21, 1'b0);
    run_op(1'b1, 5'd6, 32'd9, 32'd0, 2, 1'b1, 32'd0, 1'b0);
    run_op(1'b0, 5'd7, 32'd11, 32'd12, 0, 1'b0, 32'd0, 1'b0);
    run_op(1'b0, 5'd0, 32'd1, 32'd2, 3, 1'b0, 32'hFFFF_FFFF, 1'b0);
    run_op(1'b1, 5'd8, 32'd50, 32'd5, TIMEOUT, 1'b0, 32'd10, 1'b0);

    // Reset dropped in the middle of WAIT.
    @(negedge clock);
    issue_valid = 1'b1; issue_is_div = 1'b0; issue_rd = 5'd9;
    @(negedge clock);
    issue_valid = 1'b0;
    repeat (6) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("midrst_stall", 64'(stall), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_outs", 64'({md_ctrl_mult, md_ctrl_div, wb_en, exc_flag}), 64'd0);
    @(negedge clock);
    reset = 1'b1; md_ready = 1'b1; md_exception = 1'b1; md_result = 32'h1234;
    quiet = 0;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (stall || busy || wb_en || exc_flag || md_ctrl_mult || md_ctrl_div) quiet++;
      @(negedge clock);
    end
    md_ready = 1'b0;
    chk("late_ready_ignored", 64'(quiet), 64'd0);
    run_op(1'b0, 5'd10, 32'd6, 32'd6, 2, 1'b0, 32'd36, 1'b0);

    run_op(1'b0, 5'd3, 32'd2, 32'd2, 2, 1'b0, 32'd4, 1'b1);
    run_op(1'b0, 5'd4, 32'd5, 32'd5, 1, 1'b0, 32'd25, 1'b0);

    for (int n = 0; n < 20; n++) begin
      logic [4:0] rd;
      int k;
      rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      k  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, TIMEOUT));
      run_op(1'($urandom), rd, $urandom, $urandom, k, ($urandom_range(0, 3) == 0),
             $urandom, 1'($urandom));
    end

    @(negedge clock);
    issue_valid = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
